// File: rtl/ika87ad_mcseq.sv
// ---------------------------------------------------------------------------
// ika87ad_mcseq -- microcode sequencer sitting directly upstream of the
// microcode ROM.
//
// Accepts a ROM entry address from the opcode decoder, strobes the ROM read,
// latches each 18-bit microword and hands it to the execution stage. It also
// inserts NOP wait cycles, launches and awaits bus cycles, steps to the next
// microword and reports when the instruction retires.
//
// Ports
//   i_CLK, i_RST_n         clock, asynchronous active-low reset
//   i_CEN                  clock enable; all state advances only when high
//   i_OPCODE_VALID         decoder has an entry address ready
//   i_MC_ENTRY[7:0]        entry address of the decoded opcode
//   i_SKIP                 PSW skip flag, sampled when the opcode is accepted
//   o_DECODE_REQ           sequencer idle, ready to accept an opcode
//   o_MCROM_READ_TICK      one-cycle ROM read strobe
//   o_MCROM_ADDR[7:0]      ROM address
//   i_MCROM_DATA[17:0]     registered ROM output, valid one enabled cycle
//                          after the tick
//   o_MC_WORD[17:0]        latched microword
//   o_MC_VALID             pulse: o_MC_WORD is to be executed
//   o_BUS_START            pulse: launch bus cycle o_BUS_CODE
//   o_BUS_CODE[1:0]        00 IDLE, 01 RD3, 10 RD4, 11 WR3
//   i_BUS_DONE             bus unit finished the current cycle
//   o_INSTR_DONE           pulse: final microword retired
//   o_MC_FAULT             bus-wait watchdog fault, sticky until reset
//
// Build option
//   IKA87AD_MCSEQ_WDT_EN   when defined, a watchdog aborts a bus wait that
//                          lasts WDT_LIMIT enabled cycles; otherwise the bus
//                          wait is unbounded and o_MC_FAULT is tied low.
// ---------------------------------------------------------------------------
module ika87ad_mcseq #(
  parameter int WDT_LIMIT = 255
) (
  input  logic        i_CLK,
  input  logic        i_RST_n,
  input  logic        i_CEN,
  input  logic        i_OPCODE_VALID,
  input  logic [7:0]  i_MC_ENTRY,
  input  logic        i_SKIP,
  output logic        o_DECODE_REQ,
  output logic        o_MCROM_READ_TICK,
  output logic [7:0]  o_MCROM_ADDR,
  input  logic [17:0] i_MCROM_DATA,
  output logic [17:0] o_MC_WORD,
  output logic        o_MC_VALID,
  output logic        o_BUS_START,
  output logic [1:0]  o_BUS_CODE,
  input  logic        i_BUS_DONE,
  output logic        o_INSTR_DONE,
  output logic        o_MC_FAULT
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ROM   = 3'd1,
    S_EXEC  = 3'd2,
    S_WAIT  = 3'd3,
    S_BUS   = 3'd4,
    S_BWAIT = 3'd5,
    S_NEXT  = 3'd6
  } state_t;

  state_t      r_state;
  logic [7:0]  r_addr;
  logic        r_skip;
  logic [17:0] r_word;
  logic [3:0]  r_wait;
  logic        r_decode_req;
  logic        r_tick;
  logic        r_mc_valid;
  logic        r_bus_start;
  logic [1:0]  r_bus_code;
  logic        r_instr_done;

  // Field views of the incoming ROM word (consumed in S_EXEC) and of the
  // latched word (consumed in S_BUS / S_NEXT).
  logic       w_rom_skipchk;
  logic       w_rom_wait_req;
  logic       w_word_end;
  logic [1:0] w_word_bus;

  assign w_rom_skipchk  = i_MCROM_DATA[14];
  assign w_rom_wait_req = (i_MCROM_DATA[17:16] == 2'b11) && i_MCROM_DATA[13] &&
                          (i_MCROM_DATA[12:9] != 4'd0);
  assign w_word_end     = r_word[15];
  assign w_word_bus     = r_word[1:0];

`ifdef IKA87AD_MCSEQ_WDT_EN
  localparam logic [7:0] LP_WDT_LAST = 8'(WDT_LIMIT - 1);
  logic [7:0] r_wdt;
  logic       r_fault;
`endif

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_state      <= S_IDLE;
      r_addr       <= 8'd0;
      r_skip       <= 1'b0;
      r_word       <= 18'd0;
      r_wait       <= 4'd0;
      r_decode_req <= 1'b1;
      r_tick       <= 1'b0;
      r_mc_valid   <= 1'b0;
      r_bus_start  <= 1'b0;
      r_bus_code   <= 2'b00;
      r_instr_done <= 1'b0;
`ifdef IKA87AD_MCSEQ_WDT_EN
      r_wdt        <= 8'd0;
      r_fault      <= 1'b0;
`endif
    end else if (i_CEN) begin
      // Pulse registers fall back to 0 every enabled cycle unless re-fired.
      r_tick       <= 1'b0;
      r_mc_valid   <= 1'b0;
      r_bus_start  <= 1'b0;
      r_instr_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_OPCODE_VALID) begin
            r_addr       <= i_MC_ENTRY;
            r_tick       <= 1'b1;
            r_skip       <= i_SKIP;
            r_decode_req <= 1'b0;
            r_state      <= S_ROM;
          end
        end
        S_ROM: begin
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_word     <= i_MCROM_DATA;
          // A skipped word is still sequenced (and its bus cycle still runs);
          // only its execute strobe is withheld.
          r_mc_valid <= !(r_skip && w_rom_skipchk);
          if (w_rom_wait_req) begin
            r_wait  <= i_MCROM_DATA[12:9];
            r_state <= S_WAIT;
          end else begin
            r_state <= S_BUS;
          end
        end
        S_WAIT: begin
          r_wait <= r_wait - 4'd1;
          if (r_wait == 4'd1) begin
            r_state <= S_BUS;
          end
        end
        S_BUS: begin
          if (w_word_bus == 2'b00) begin
            r_state <= S_NEXT;
          end else begin
            r_bus_start <= 1'b1;
            r_bus_code  <= w_word_bus;
            r_state     <= S_BWAIT;
`ifdef IKA87AD_MCSEQ_WDT_EN
            r_wdt       <= 8'd0;
`endif
          end
        end
        S_BWAIT: begin
          // r_bus_start still set means this is the cycle the start pulse is
          // visible; a done seen there belongs to an earlier bus cycle.
          if (i_BUS_DONE && !r_bus_start) begin
            r_bus_code <= 2'b00;
            r_state    <= S_NEXT;
          end
`ifdef IKA87AD_MCSEQ_WDT_EN
          else if (r_wdt == LP_WDT_LAST) begin
            r_fault      <= 1'b1;
            r_instr_done <= 1'b1;
            r_bus_code   <= 2'b00;
            r_skip       <= 1'b0;
            r_decode_req <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_wdt <= r_wdt + 8'd1;
          end
`endif
        end
        S_NEXT: begin
          if (w_word_end) begin
            r_instr_done <= 1'b1;
            r_skip       <= 1'b0;
            r_decode_req <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_addr  <= r_addr + 8'd1;
            r_tick  <= 1'b1;
            r_state <= S_ROM;
          end
        end
        default: begin
          r_decode_req <= 1'b1;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  // Pulse registers hold while i_CEN is low; gating them with i_CEN makes
  // each pulse visible in exactly one enabled cycle.
  assign o_DECODE_REQ      = r_decode_req;
  assign o_MCROM_READ_TICK = r_tick & i_CEN;
  assign o_MCROM_ADDR      = r_addr;
  assign o_MC_WORD         = r_word;
  assign o_MC_VALID        = r_mc_valid & i_CEN;
  assign o_BUS_START       = r_bus_start & i_CEN;
  assign o_BUS_CODE        = r_bus_code;
  assign o_INSTR_DONE      = r_instr_done & i_CEN;

`ifdef IKA87AD_MCSEQ_WDT_EN
  assign o_MC_FAULT = r_fault;
`else
  assign o_MC_FAULT = 1'b0;
`endif

endmodule

// File: tb/tb_ika87ad_mcseq.sv
// ---------------------------------------------------------------------------
// Testbench for ika87ad_mcseq: a cycle-by-cycle vector table for a basic
// two-word routine followed by hand-written sequences for waits, skip,
// clock-enable stretching, address wrap, reset mid-bus-cycle and (when built
// with IKA87AD_MCSEQ_WDT_EN) the bus watchdog.
// ---------------------------------------------------------------------------
module tb_ika87ad_mcseq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_CEN;
  logic        i_OPCODE_VALID;
  logic [7:0]  i_MC_ENTRY;
  logic        i_SKIP;
  logic        o_DECODE_REQ;
  logic        o_MCROM_READ_TICK;
  logic [7:0]  o_MCROM_ADDR;
  logic [17:0] rom_q;
  logic [17:0] o_MC_WORD;
  logic        o_MC_VALID;
  logic        o_BUS_START;
  logic [1:0]  o_BUS_CODE;
  logic        i_BUS_DONE;
  logic        o_INSTR_DONE;
  logic        o_MC_FAULT;

  always #5 clk = ~clk;

  ika87ad_mcseq #(.WDT_LIMIT(4)) dut (
    .i_CLK            (clk),
    .i_RST_n          (rst_n),
    .i_CEN            (i_CEN),
    .i_OPCODE_VALID   (i_OPCODE_VALID),
    .i_MC_ENTRY       (i_MC_ENTRY),
    .i_SKIP           (i_SKIP),
    .o_DECODE_REQ     (o_DECODE_REQ),
    .o_MCROM_READ_TICK(o_MCROM_READ_TICK),
    .o_MCROM_ADDR     (o_MCROM_ADDR),
    .i_MCROM_DATA     (rom_q),
    .o_MC_WORD        (o_MC_WORD),
    .o_MC_VALID       (o_MC_VALID),
    .o_BUS_START      (o_BUS_START),
    .o_BUS_CODE       (o_BUS_CODE),
    .i_BUS_DONE       (i_BUS_DONE),
    .o_INSTR_DONE     (o_INSTR_DONE),
    .o_MC_FAULT       (o_MC_FAULT)
  );

  // Registered microcode ROM model.
  logic [17:0] rom [256];
  always @(posedge clk) if (o_MCROM_READ_TICK) rom_q <= rom[o_MCROM_ADDR];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [32:0] pk(input logic req, input logic tick, input logic [7:0] addr,
                                     input logic mcv, input logic st, input logic [1:0] code,
                                     input logic id, input logic [17:0] w);
    return {req, tick, addr, mcv, st, code, id, w};
  endfunction

  function automatic logic [32:0] dut_vec();
    return pk(o_DECODE_REQ, o_MCROM_READ_TICK, o_MCROM_ADDR, o_MC_VALID, o_BUS_START,
              o_BUS_CODE, o_INSTR_DONE, o_MC_WORD);
  endfunction

  typedef struct {
    logic        v;
    logic [7:0]  e;
    logic        d;
    logic [32:0] x;
  } vec_t;

  vec_t tbl [18];

  // Runs one routine from S_IDLE. The bus unit answers two cycles after each
  // start pulse; i_CEN is dropped for cycles cen_off and cen_off+1 if >= 0.
  task automatic run_seq(input logic [7:0] entry, input logic skip, input int cen_off,
                         output int n_valid, output int n_start, output int n_tick,
                         output int valid_cyc, output int tick2_cyc, output int done_cyc,
                         output logic [7:0] addr2, output logic [1:0] code);
    int start_cyc;
    bit fin;
    n_valid = 0; n_start = 0; n_tick = 0; valid_cyc = -1; tick2_cyc = -1;
    done_cyc = -1; addr2 = 8'h00; code = 2'b00; start_cyc = -1; fin = 0;
    for (int c = 0; c < 80 && !fin; c++) begin
      i_CEN          = !(cen_off >= 0 && (c == cen_off || c == cen_off + 1));
      i_OPCODE_VALID = (c == 0);
      i_MC_ENTRY     = entry;
      i_SKIP         = skip;
      i_BUS_DONE     = (start_cyc >= 0 && c >= start_cyc + 2);
      @(negedge clk);
      if (o_MC_VALID) begin
        n_valid++;
        if (valid_cyc < 0) valid_cyc = c;
      end
      if (o_MCROM_READ_TICK) begin
        n_tick++;
        if (n_tick == 2) begin
          tick2_cyc = c;
          addr2 = o_MCROM_ADDR;
        end
      end
      if (o_BUS_START) begin
        n_start++;
        code = o_BUS_CODE;
        start_cyc = c;
      end
      if (o_INSTR_DONE) begin
        done_cyc = c;
        fin = 1;
      end
      @(posedge clk); #1;
    end
    i_OPCODE_VALID = 1'b0;
    i_BUS_DONE = 1'b0;
    i_SKIP = 1'b0;
    i_CEN = 1'b1;
    chk("seq_done_in_bound", 64'(fin), 64'd1);
  endtask

  initial begin
    int nv, ns, nt, vc, t2, dc, nv2, ns2, nt2, vc2, t22, dc2;
    logic [7:0] a2, a22;
    logic [1:0] cd, cd2;
    int sc;
    bit got;

    for (int i = 0; i < 256; i++) rom[i] = 18'h0;
    rom[8'h10] = 18'h00000;  // END=0, bus 00
    rom[8'h11] = 18'h08002;  // END=1, bus RD4
    rom[8'h20] = 18'h08000;  // END=1, bus 00
    rom[8'h30] = 18'h32400;  // MCTYPE3, NOP, wait 2
    rom[8'h31] = 18'h08000;
    rom[8'h40] = 18'h00000;
    rom[8'h41] = 18'h08000;
    rom[8'h50] = 18'h12400;  // MCTYPE1: NOP/wait fields must be ignored
    rom[8'h51] = 18'h08000;
    rom[8'h60] = 18'h0C001;  // END, SKIPCHK, bus RD3
    rom[8'hFF] = 18'h00000;  // END=0, wraps to 00
    rom[8'h00] = 18'h00001;  // bus RD3, never completed
    rom[8'h70] = 18'h08003;  // END, bus WR3

    //            v     entry  done  req tick addr   mcv st code  id word
    tbl[0]  = '{1'b1, 8'h10, 1'b0, pk(1, 0, 8'h00, 0, 0, 2'd0, 0, 18'h00000)};
    tbl[1]  = '{1'b0, 8'h10, 1'b0, pk(0, 1, 8'h10, 0, 0, 2'd0, 0, 18'h00000)};
    tbl[2]  = '{1'b0, 8'h10, 1'b0, pk(0, 0, 8'h10, 0, 0, 2'd0, 0, 18'h00000)};
    tbl[3]  = '{1'b0, 8'h10, 1'b0, pk(0, 0, 8'h10, 1, 0, 2'd0, 0, 18'h00000)};
    tbl[4]  = '{1'b0, 8'h10, 1'b0, pk(0, 0, 8'h10, 0, 0, 2'd0, 0, 18'h00000)};
    tbl[5]  = '{1'b0, 8'h10, 1'b0, pk(0, 1, 8'h11, 0, 0, 2'd0, 0, 18'h00000)};
    tbl[6]  = '{1'b0, 8'h10, 1'b0, pk(0, 0, 8'h11, 0, 0, 2'd0, 0, 18'h00000)};
    tbl[7]  = '{1'b0, 8'h10, 1'b0, pk(0, 0, 8'h11, 1, 0, 2'd0, 0, 18'h08002)};
    tbl[8]  = '{1'b0, 8'h10, 1'b1, pk(0, 0, 8'h11, 0, 1, 2'd2, 0, 18'h08002)};
    tbl[9]  = '{1'b0, 8'h10, 1'b1, pk(0, 0, 8'h11, 0, 0, 2'd2, 0, 18'h08002)};
    tbl[10] = '{1'b1, 8'h20, 1'b0, pk(0, 0, 8'h11, 0, 0, 2'd0, 0, 18'h08002)};
    tbl[11] = '{1'b1, 8'h20, 1'b0, pk(1, 0, 8'h11, 0, 0, 2'd0, 1, 18'h08002)};
    tbl[12] = '{1'b0, 8'h20, 1'b0, pk(0, 1, 8'h20, 0, 0, 2'd0, 0, 18'h08002)};
    tbl[13] = '{1'b0, 8'h20, 1'b0, pk(0, 0, 8'h20, 0, 0, 2'd0, 0, 18'h08002)};
    tbl[14] = '{1'b0, 8'h20, 1'b0, pk(0, 0, 8'h20, 1, 0, 2'd0, 0, 18'h08000)};
    tbl[15] = '{1'b0, 8'h20, 1'b0, pk(0, 0, 8'h20, 0, 0, 2'd0, 0, 18'h08000)};
    tbl[16] = '{1'b0, 8'h20, 1'b0, pk(1, 0, 8'h20, 0, 0, 2'd0, 1, 18'h08000)};
    tbl[17] = '{1'b0, 8'h20, 1'b0, pk(1, 0, 8'h20, 0, 0, 2'd0, 0, 18'h08000)};

    // Reset
    rst_n = 1'b0; i_CEN = 1'b1; i_OPCODE_VALID = 1'b0; i_MC_ENTRY = 8'h00;
    i_SKIP = 1'b0; i_BUS_DONE = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 64'({dut_vec(), o_MC_FAULT}), 64'({pk(1, 0, 8'h00, 0, 0, 2'd0, 0, 18'h0), 1'b0}));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic routine: vector table
    for (int k = 0; k < 18; k++) begin
      i_OPCODE_VALID = tbl[k].v;
      i_MC_ENTRY     = tbl[k].e;
      i_BUS_DONE     = tbl[k].d;
      @(negedge clk);
      chk($sformatf("vec%0d", k), 64'(dut_vec()), 64'(tbl[k].x));
      $display("vec %0d: outputs %0h", k, dut_vec());
      @(posedge clk); #1;
    end
    i_OPCODE_VALID = 1'b0;
    i_BUS_DONE = 1'b0;

    // NOP wait of 2 vs no wait vs MCTYPE!=3
    run_seq(8'h30, 1'b0, -1, nv, ns, nt, vc, t2, dc, a2, cd);
    $display("nop wait: valid@%0d tick2@%0d done@%0d", vc, t2, dc);
    chk("nop_wait_gap", 64'(t2 - vc), 64'd4);
    run_seq(8'h40, 1'b0, -1, nv, ns, nt, vc, t2, dc, a2, cd);
    $display("no wait: valid@%0d tick2@%0d done@%0d", vc, t2, dc);
    chk("nowait_gap", 64'(t2 - vc), 64'd2);
    run_seq(8'h50, 1'b0, -1, nv, ns, nt, vc, t2, dc, a2, cd);
    $display("mctype1 nop: valid@%0d tick2@%0d done@%0d", vc, t2, dc);
    chk("mctype1_no_wait", 64'(t2 - vc), 64'd2);

    // Skip: valid suppressed, bus cycle and completion still happen
    run_seq(8'h60, 1'b1, -1, nv, ns, nt, vc, t2, dc, a2, cd);
    $display("skip=1: valid=%0d start=%0d code=%0d done@%0d", nv, ns, cd, dc);
    chk("skip_valid_suppressed", 64'(nv), 64'd0);
    chk("skip_bus_start", 64'(ns), 64'd1);
    chk("skip_bus_code", 64'(cd), 64'd1);
    run_seq(8'h60, 1'b0, -1, nv, ns, nt, vc, t2, dc, a2, cd);
    $display("skip=0: valid=%0d start=%0d done@%0d", nv, ns, dc);
    chk("noskip_valid", 64'(nv), 64'd1);

    // Clock enable stretch
    run_seq(8'h10, 1'b0, -1, nv, ns, nt, vc, t2, dc, a2, cd);
    $display("cen ref: valid=%0d start=%0d ticks=%0d done@%0d", nv, ns, nt, dc);
    run_seq(8'h10, 1'b0, 3, nv2, ns2, nt2, vc2, t22, dc2, a22, cd2);
    $display("cen 1001: valid=%0d start=%0d ticks=%0d done@%0d", nv2, ns2, nt2, dc2);
    chk("cen_stretch_done", 64'(dc2), 64'(dc + 2));
    chk("cen_valid_count", 64'(nv2), 64'd2);
    chk("cen_start_count", 64'(ns2), 64'd1);
    chk("cen_tick_count", 64'(nt2), 64'd2);
    chk("cen_bus_code", 64'(cd2), 64'd2);

    // Address wrap, then reset while waiting on the bus
    got = 0; a2 = 8'h00; nt = 0; sc = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      i_OPCODE_VALID = (c == 0);
      i_MC_ENTRY = 8'hFF;
      @(negedge clk);
      if (o_MCROM_READ_TICK) begin
        nt++;
        if (nt == 2) a2 = o_MCROM_ADDR;
      end
      if (o_BUS_START) got = 1;
      @(posedge clk); #1;
    end
    i_OPCODE_VALID = 1'b0;
    $display("wrap: second tick addr %0h, bus started %0d", a2, got);
    chk("wrap_addr", 64'(a2), 64'h00);
    chk("wrap_bus_started", 64'(got), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    $display("reset in bwait: outputs %0h", dut_vec());
    chk("rst_mid_bus", 64'(dut_vec()), 64'(pk(1, 0, 8'h00, 0, 0, 2'd0, 0, 18'h0)));
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      @(negedge clk);
      if (o_INSTR_DONE || o_MC_VALID || o_BUS_START || o_MCROM_READ_TICK) sc++;
    end
    chk("rst_no_pulses", 64'(sc), 64'd0);
    chk("rst_decode_req", 64'(o_DECODE_REQ), 64'd1);
    @(posedge clk); #1;

`ifdef IKA87AD_MCSEQ_WDT_EN
    got = 0; sc = -1; dc = -1;
    for (int c = 0; c < 40 && !got; c++) begin
      i_OPCODE_VALID = (c == 0);
      i_MC_ENTRY = 8'h70;
      @(negedge clk);
      if (o_BUS_START) sc = c;
      if (o_MC_FAULT) begin
        got = 1;
        dc = c;
        chk("wdt_instr_done", 64'(o_INSTR_DONE), 64'd1);
      end
      @(posedge clk); #1;
    end
    i_OPCODE_VALID = 1'b0;
    $display("wdt: start@%0d fault@%0d", sc, dc);
    chk("wdt_fault_seen", 64'(got), 64'd1);
    chk("wdt_latency", 64'(dc - sc), 64'd4);
    @(negedge clk);
    chk("wdt_idle_sticky", 64'({o_DECODE_REQ, o_MC_FAULT}), 64'b11);
`else
    $display("fault output: %0d", o_MC_FAULT);
    chk("fault_tied_low", 64'(o_MC_FAULT), 64'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
